mealy_output_packer: RTL and testbench
======================================

MEALY_OUTPUT_PACKER -- requirements
Module: mealy_output_packer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning serial bits per frame (legal 2..16).
REQ-002 SHALL have parameter DROP_W, default 8, meaning width of the dropped-frame counter.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port x  input  1  serial input bit fed to the Mealy detector.
REQ-006 SHALL have port z  input  1  Mealy detector output for the same cycle as x.
REQ-007 SHALL have port in_valid  input  1  x/z pair is valid this cycle.
REQ-008 SHALL have port frame_data  output  FRAME_LEN  packed x bits, first-received bit in MSB.
REQ-009 SHALL have port frame_hits  output  $clog2(FRAME_LEN+1)  count of z=1 samples in the frame.
REQ-010 SHALL have port frame_valid  output  1  output frame held and valid.
REQ-011 SHALL have port frame_ready  input  1  consumer accepts the frame when high with frame_valid.
REQ-012 SHALL have port drop_count  output  DROP_W  saturating count of frames lost to backpressure.

Function
REQ-013 SHALL sample x and z only on cycles with in_valid=1; other cycles change no collector state.
REQ-014 SHALL shift each valid x into a collector register, MSB-first, and advance bit index 0..FRAME_LEN-1.
REQ-015 SHALL increment the collector hit count on each valid sample with z=1, including the final bit.
REQ-016 SHALL complete a frame on the valid sample at bit index FRAME_LEN-1, then restart the index at 0 next cycle with the hit count cleared.
REQ-017 SHALL run output FSM states OUT_EMPTY and OUT_FULL; frame_valid=1 exactly in OUT_FULL.
REQ-018 SHALL move OUT_EMPTY->OUT_FULL on frame completion, loading frame_data/frame_hits; frame_valid rises the cycle after the final bit (latency 1).
REQ-019 SHALL move OUT_FULL->OUT_EMPTY on frame_valid&&frame_ready with no completion that cycle.
REQ-020 SHALL, when a handshake and a completion occur in the same cycle, load the new frame and stay OUT_FULL (no drop).
REQ-021 SHALL, on completion in OUT_FULL without a handshake, discard the new frame, keep the held frame unchanged and increment drop_count, saturating at all-ones.
REQ-022 SHALL hold frame_data and frame_hits stable while frame_valid=1 and frame_ready=0.
REQ-023 SHALL treat frame_ready as don't-care in OUT_EMPTY.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, clear bit index, collector and hit count, enter OUT_EMPTY, drive frame_valid=0, frame_data=0, frame_hits=0, drop_count=0.
REQ-025 SHALL discard a partial frame when reset asserts mid-frame; the first valid sample after reset is bit 0.
REQ-026 SHALL give reset priority over in_valid and frame_ready in the same cycle.

Configuration
REQ-027 SHALL, with PACKER_PARITY_EN defined, add output frame_parity (1 bit) = even parity (XOR) of frame_data, registered with frame_data, reset 0.
REQ-028 SHALL, without PACKER_PARITY_EN, omit frame_parity port and its logic entirely.

Structure
REQ-029 SHALL place FRAME_LEN default, output FSM state typedef (OUT_EMPTY, OUT_FULL) and the hit-width helper constant in package mealy_packer_pkg.
REQ-030 SHALL implement the shift register, bit index and hit counter in one sub-module, mealy_bit_collector, producing a one-cycle frame_done strobe with collected data and hits.

Verification
REQ-031 SHALL check: reset, then x=0,1,1,1,0,1,0,0 with z=0,0,1,0,1,0,0,1, in_valid=1, frame_ready=1 -> frame_valid for 1 cycle, frame_data=8'h74, frame_hits=3.
REQ-032 SHALL check: in_valid toggled 1,0,1,0 across one frame -> identical frame_data/frame_hits to gapless case; frame_valid one cycle after the 8th valid sample.
REQ-033 SHALL check: frame_ready=0 for two full frames -> first frame held unchanged, drop_count=1; frame_ready=1 then accepts first frame, frame_valid falls.
REQ-034 SHALL check: frame_ready pulsed in the exact cycle of the next frame's final bit -> new frame loaded, frame_valid stays 1, drop_count unchanged.
REQ-035 SHALL check: reset asserted after 5 valid bits -> outputs zero; next 8 valid bits form a complete frame with correct data.
REQ-036 SHALL check: PACKER_PARITY_EN defined, frame_data=8'h74 -> frame_parity=0; frame_data=8'h75 -> frame_parity=1.

Source files
------------

// File: rtl/mealy_packer_pkg.sv
`default_nettype none
// mealy_packer_pkg: shared frame length default, output FSM state type and hit-width helper.
package mealy_packer_pkg;

  localparam int FRAME_LEN_DEFAULT = 8;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width needed to count 0..frame_len hits inclusive.
  function automatic int hit_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  localparam int HIT_W_DEFAULT = hit_width(FRAME_LEN_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/mealy_bit_collector.sv
`default_nettype none
// mealy_bit_collector: shifts valid x bits MSB-first, counts z hits, strobes frame_done on the last bit.
module mealy_bit_collector
  import mealy_packer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int HIT_W     = hit_width(FRAME_LEN)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 z,
  input  logic                 in_valid,
  output logic                 frame_done,
  output logic [FRAME_LEN-1:0] done_data,
  output logic [HIT_W-1:0]     done_hits
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam int               SH_W     = FRAME_LEN - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [HIT_W-1:0] hits_next;
  logic             last_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      shift_q <= '0;
      hits_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hits_q  <= hits_d;
    end
  end

  // The final bit is never stored; the completed frame is presented combinationally.
  always_comb begin
    last_bit   = in_valid && (idx_q == LAST_IDX);
    hits_next  = hits_q + HIT_W'(z);
    frame_done = last_bit;
    done_data  = {shift_q, x};
    done_hits  = hits_next;
    idx_d      = idx_q;
    shift_d    = shift_q;
    hits_d     = hits_q;
    if (in_valid) begin
      if (last_bit) begin
        idx_d   = '0;
        shift_d = '0;
        hits_d  = '0;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        shift_d = SH_W'({shift_q, x});
        hits_d  = hits_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mealy_output_packer.sv
`default_nettype none
// mealy_output_packer: packs Mealy x/z samples into frames behind a one-entry output holding register.
// Optional macro PACKER_PARITY_EN adds a registered even-parity output frame_parity.
module mealy_output_packer
  import mealy_packer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int DROP_W    = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             x,
  input  logic                             z,
  input  logic                             in_valid,
  output logic [FRAME_LEN-1:0]             frame_data,
  output logic [$clog2(FRAME_LEN+1)-1:0]   frame_hits,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [DROP_W-1:0]                drop_count
`ifdef PACKER_PARITY_EN
  ,
  output logic                             frame_parity
`endif
);

  localparam int                HIT_W    = hit_width(FRAME_LEN);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic                 done;
  logic [FRAME_LEN-1:0] done_data;
  logic [HIT_W-1:0]     done_hits;

  out_state_e           state_q, state_d;
  logic [FRAME_LEN-1:0] data_q, data_d;
  logic [HIT_W-1:0]     hits_q, hits_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 handshake;
  logic                 load;
  logic                 drop;

  mealy_bit_collector #(
    .FRAME_LEN (FRAME_LEN),
    .HIT_W     (HIT_W)
  ) u_collector (
    .clock      (clock),
    .reset      (reset),
    .x          (x),
    .z          (z),
    .in_valid   (in_valid),
    .frame_done (done),
    .done_data  (done_data),
    .done_hits  (done_hits)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A completion arriving while the held frame is taken simply replaces it.
  always_comb begin
    handshake = (state_q == OUT_FULL) && frame_ready;
    load      = 1'b0;
    drop      = 1'b0;
    state_d   = state_q;
    case (state_q)
      OUT_EMPTY: begin
        if (done) begin
          state_d = OUT_FULL;
          load    = 1'b1;
        end
      end
      OUT_FULL: begin
        if (done) begin
          if (handshake) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (handshake) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      hits_q <= '0;
      drop_q <= '0;
    end else begin
      data_q <= data_d;
      hits_q <= hits_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    data_d = load ? done_data : data_q;
    hits_d = load ? done_hits : hits_q;
    drop_d = (drop && (drop_q != DROP_MAX)) ? drop_q + DROP_W'(1) : drop_q;
  end

`ifdef PACKER_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  always_comb begin
    parity_d = load ? ^done_data : parity_q;
  end

  assign frame_parity = parity_q;
`endif

  always_comb begin
    frame_valid = (state_q == OUT_FULL);
    frame_data  = data_q;
    frame_hits  = hits_q;
    drop_count  = drop_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mealy_output_packer.sv
`default_nettype none
// tb_mealy_output_packer: directed and randomized scoreboard bench for mealy_output_packer.
module tb_mealy_output_packer;

  localparam int FL       = 8;
  localparam int HW       = $clog2(FL + 1);
  localparam int DW       = 3;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          x;
  logic          z;
  logic          in_valid;
  logic          frame_ready;
  logic [FL-1:0] frame_data;
  logic [HW-1:0] frame_hits;
  logic          frame_valid;
  logic [DW-1:0] drop_count;
`ifdef PACKER_PARITY_EN
  logic          frame_parity;
`endif

  mealy_output_packer #(
    .FRAME_LEN (FL),
    .DROP_W    (DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .x           (x),
    .z           (z),
    .in_valid    (in_valid),
    .frame_data  (frame_data),
    .frame_hits  (frame_hits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .drop_count  (drop_count)
`ifdef PACKER_PARITY_EN
    ,
    .frame_parity (frame_parity)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [FL-1:0] data;
    logic [HW-1:0] hits;
  } frame_t;

  // Reference model: a bit list per frame plus a one-slot holding buffer.
  frame_t exp_q[$];
  bit     m_bits[$];
  int     m_hitcnt = 0;
  bit     m_full   = 0;
  int     m_drops  = 0;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic xi, input logic zi, input logic vi,
                            input logic ri, input logic rsti);
    bit            hs;
    bit            done;
    frame_t        f;
    logic [FL-1:0] fd;
    if (rsti) begin
      m_bits.delete();
      m_hitcnt = 0;
      m_full   = 0;
      m_drops  = 0;
      exp_q.delete();
      return;
    end
    hs   = m_full && ri;
    done = 0;
    fd   = '0;
    if (vi) begin
      m_bits.push_back(xi);
      m_hitcnt += int'(zi);
      if (m_bits.size() == FL) begin
        done = 1;
        foreach (m_bits[i]) fd = {fd[FL-2:0], m_bits[i]};
        f.data = fd;
        f.hits = HW'(m_hitcnt);
        m_bits.delete();
        m_hitcnt = 0;
      end
    end
    if (done) begin
      if (!m_full || hs) begin
        exp_q.push_back(f);
        m_full = 1;
      end else if (m_drops < DROP_MAX) begin
        m_drops++;
      end
    end else if (hs) begin
      m_full = 0;
    end
  endtask

  task automatic cyc(input logic xi, input logic zi, input logic vi,
                     input logic ri, input logic rsti);
    x           = xi;
    z           = zi;
    in_valid    = vi;
    frame_ready = ri;
    reset       = rsti;
    @(posedge clock);
    model_step(xi, zi, vi, ri, rsti);
    #1;
  endtask

  task automatic send_frame(input logic [FL-1:0] d, input logic [FL-1:0] zs,
                            input logic rdy, input logic rdy_last, input bit gaps);
    for (int i = FL - 1; i >= 0; i--) begin
      cyc(d[i], zs[i], 1'b1, (i == 0) ? rdy_last : rdy, 1'b0);
      if (gaps && i != 0) cyc(1'($urandom), 1'($urandom), 1'b0, rdy, 1'b0);
    end
  endtask

  // Monitor: compares the held frame against the scoreboard head every cycle, pops on handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("mon_valid", 32'(frame_valid), 32'(m_full));
      chk("mon_drops", 32'(drop_count), 32'(m_drops));
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_frame: got valid=1 data=%0h expected no frame", frame_data);
        end else begin
          chk("mon_data", 32'(frame_data), 32'(exp_q[0].data));
          chk("mon_hits", 32'(frame_hits), 32'(exp_q[0].hits));
`ifdef PACKER_PARITY_EN
          chk("mon_parity", 32'(frame_parity), 32'(^exp_q[0].data));
`endif
          if (frame_ready && !reset) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int mode;
    logic rdy;
    reset       = 1'b1;
    x           = 1'b0;
    z           = 1'b0;
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    mon_en = 1;
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_data", 32'(frame_data), 32'd0);
    chk("reset_hits", 32'(frame_hits), 32'd0);
    chk("reset_drops", 32'(drop_count), 32'd0);
`ifdef PACKER_PARITY_EN
    chk("reset_parity", 32'(frame_parity), 32'd0);
`endif

    // Gapless frame, consumer always ready
    send_frame(8'h74, 8'h29, 1'b1, 1'b1, 0);
    chk("basic_valid", 32'(frame_valid), 32'd1);
    chk("basic_data", 32'(frame_data), 32'h74);
    chk("basic_hits", 32'(frame_hits), 32'd3);
`ifdef PACKER_PARITY_EN
    chk("parity_74", 32'(frame_parity), 32'd0);
`endif
    cyc(0, 0, 0, 1, 0);
    chk("basic_one_cycle", 32'(frame_valid), 32'd0);

    // Same frame with idle cycles between samples
    send_frame(8'h74, 8'h29, 1'b1, 1'b1, 1);
    chk("gap_valid", 32'(frame_valid), 32'd1);
    chk("gap_data", 32'(frame_data), 32'h74);
    chk("gap_hits", 32'(frame_hits), 32'd3);
    cyc(0, 0, 0, 1, 0);

    // Backpressure across two frames: second one is dropped
    send_frame(8'h74, 8'h29, 1'b0, 1'b0, 0);
    chk("bp_first_valid", 32'(frame_valid), 32'd1);
    send_frame(8'hC3, 8'h0F, 1'b0, 1'b0, 0);
    chk("bp_held_data", 32'(frame_data), 32'h74);
    chk("bp_held_hits", 32'(frame_hits), 32'd3);
    chk("bp_drops", 32'(drop_count), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("bp_accept_falls", 32'(frame_valid), 32'd0);

    // Handshake coincides with the next frame's final bit
    send_frame(8'h75, 8'hFF, 1'b0, 1'b0, 0);
    chk("full_hits", 32'(frame_hits), 32'd8);
`ifdef PACKER_PARITY_EN
    chk("parity_75", 32'(frame_parity), 32'd1);
`endif
    send_frame(8'h3C, 8'h00, 1'b0, 1'b1, 0);
    chk("swap_valid", 32'(frame_valid), 32'd1);
    chk("swap_data", 32'(frame_data), 32'h3C);
    chk("swap_hits", 32'(frame_hits), 32'd0);
    chk("swap_drops", 32'(drop_count), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // Reset after a partial frame
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1);
    chk("midreset_valid", 32'(frame_valid), 32'd0);
    chk("midreset_data", 32'(frame_data), 32'd0);
    chk("midreset_hits", 32'(frame_hits), 32'd0);
    chk("midreset_drops", 32'(drop_count), 32'd0);
    send_frame(8'h96, 8'h5A, 1'b1, 1'b1, 0);
    chk("postreset_data", 32'(frame_data), 32'h96);
    chk("postreset_hits", 32'(frame_hits), 32'd4);
    cyc(0, 0, 0, 1, 0);

    // Drop counter saturation
    send_frame(8'h74, 8'h29, 1'b0, 1'b0, 0);
    for (int k = 0; k < DROP_MAX + 1; k++) send_frame(FL'($urandom), FL'($urandom), 1'b0, 1'b0, 0);
    chk("sat_drops", 32'(drop_count), 32'(DROP_MAX));
    chk("sat_held_data", 32'(frame_data), 32'h74);
    cyc(0, 0, 0, 1, 0);
    chk("sat_accept_falls", 32'(frame_valid), 32'd0);

    // Randomized traffic with varying consumer bias and occasional reset
    for (int n = 0; n < 1800; n++) begin
      mode = (n / 150) % 3;
      case (mode)
        0:       rdy = ($urandom_range(0, 9) != 0);
        1:       rdy = ($urandom_range(0, 1) == 0);
        default: rdy = ($urandom_range(0, 9) == 0);
      endcase
      cyc(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), rdy,
          ($urandom_range(0, 299) == 0));
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("drain_valid", 32'(frame_valid), 32'd0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
